// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined bitwise logic unit with valid/ready ports, zero/parity flags
// and an accepted-transaction counter. Define LU_POPCOUNT_EN to add the popcnt output.
module logic_unit_pipe #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             a,
  input  logic [WIDTH-1:0]             b,
  input  logic [2:0]                   op,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             y,
  output logic                         zero,
  output logic                         parity,
`ifdef LU_POPCOUNT_EN
  output logic [$clog2(WIDTH+1)-1:0]   popcnt,
`endif
  output logic [CNT_W-1:0]             txn_cnt
);

  typedef enum logic [2:0] {
    OP_AND    = 3'b000,
    OP_OR     = 3'b001,
    OP_XOR    = 3'b010,
    OP_NAND   = 3'b011,
    OP_NOR    = 3'b100,
    OP_XNOR   = 3'b101,
    OP_PASS_A = 3'b110,
    OP_NOT_A  = 3'b111
  } op_e;

  // Handshake: a beat transfers on a rising edge where valid & ready are both high.
  // valid never waits on ready; ready depends only on registered state and out_ready.

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  op_e              s1_op;

  logic             s1_adv;
  logic             s2_adv;
  logic             accept;

  logic [WIDTH-1:0] res;
  logic             res_zero;
  logic             res_parity;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;
  assign accept   = in_valid && in_ready;

  // Stage 1: capture operands; data registers only load on an actual accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= OP_AND;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a  <= a;
        s1_b  <= b;
        s1_op <= op_e'(op);
      end
    end
  end

  always_comb begin
    res = '0;
    unique case (s1_op)
      OP_AND:    res = s1_a & s1_b;
      OP_OR:     res = s1_a | s1_b;
      OP_XOR:    res = s1_a ^ s1_b;
      OP_NAND:   res = ~(s1_a & s1_b);
      OP_NOR:    res = ~(s1_a | s1_b);
      OP_XNOR:   res = ~(s1_a ^ s1_b);
      OP_PASS_A: res = s1_a;
      OP_NOT_A:  res = ~s1_a;
      default:   res = '0;
    endcase
  end

  assign res_zero   = ~|res;
  assign res_parity = ^res;

  // Stage 2: results only load when stage 1 holds a beat, so bubbles leave y untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      y         <= '0;
      zero      <= 1'b0;
      parity    <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        y      <= res;
        zero   <= res_zero;
        parity <= res_parity;
      end
    end
  end

`ifdef LU_POPCOUNT_EN
  localparam int PC_W = $clog2(WIDTH+1);

  logic [PC_W-1:0] res_pc;

  always_comb begin
    res_pc = '0;
    for (int i = 0; i < WIDTH; i++) begin
      res_pc = res_pc + PC_W'(res[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      popcnt <= '0;
    end else if (s2_adv && s1_valid) begin
      popcnt <= res_pc;
    end
  end
`endif

  // Wraps naturally at the counter width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txn_cnt <= '0;
    end else if (accept) begin
      txn_cnt <= txn_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe: directed scenarios plus randomized traffic
// checked by a queue-based scoreboard against a behavioural model.
module tb_logic_unit_pipe;

  localparam int W    = 32;
  localparam int CW   = 16;
  localparam int PC_W = $clog2(W+1);

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [2:0]    op;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  y;
  logic          zero;
  logic          parity;
  logic [CW-1:0] txn_cnt;
`ifdef LU_POPCOUNT_EN
  logic [PC_W-1:0] popcnt;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  logic [W-1:0]  exp_q[$];
  logic [CW-1:0] model_cnt;
  logic          prev_stall;
  logic [W-1:0]  prev_y;
  logic          prev_zero;
  logic          prev_parity;

  logic_unit_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .zero      (zero),
    .parity    (parity),
`ifdef LU_POPCOUNT_EN
    .popcnt    (popcnt),
`endif
    .txn_cnt   (txn_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] ref_op(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                          input logic [2:0] rop);
    case (rop)
      3'd0:    return ra & rb;
      3'd1:    return ra | rb;
      3'd2:    return ra ^ rb;
      3'd3:    return ~(ra & rb);
      3'd4:    return ~(ra | rb);
      3'd5:    return ~(ra ^ rb);
      3'd6:    return ra;
      default: return ~ra;
    endcase
  endfunction

  // ---------------- scoreboard ----------------
  always begin
    @(negedge clk);
    #2;
    if (!rst_n) begin
      exp_q.delete();
      model_cnt  = '0;
      prev_stall = 1'b0;
    end else begin
      tests_run++;
      if (txn_cnt !== model_cnt) begin
        tests_failed++;
        $display("FAIL sb_txn_cnt: got %h expected %h", txn_cnt, model_cnt);
      end
      if (prev_stall) begin
        tests_run++;
        if (out_valid !== 1'b1 || y !== prev_y || zero !== prev_zero || parity !== prev_parity) begin
          tests_failed++;
          $display("FAIL sb_stall_hold: got v=%b y=%h z=%b p=%b expected v=1 y=%h z=%b p=%b",
                   out_valid, y, zero, parity, prev_y, prev_zero, prev_parity);
        end
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL sb_unexpected_output: got y=%h expected no output", y);
        end else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          if (y !== e || zero !== (e == '0) || parity !== (^e)) begin
            tests_failed++;
            $display("FAIL sb_result: got y=%h z=%b p=%b expected y=%h z=%b p=%b",
                     y, zero, parity, e, (e == '0), ^e);
          end
`ifdef LU_POPCOUNT_EN
          tests_run++;
          if (popcnt !== PC_W'($countones(e))) begin
            tests_failed++;
            $display("FAIL sb_popcnt: got %0d expected %0d", popcnt, $countones(e));
          end
`endif
        end
      end
      if (in_valid === 1'b1 && in_ready === 1'b1) begin
        exp_q.push_back(ref_op(a, b, op));
        model_cnt = model_cnt + 1'b1;
      end
      prev_stall  = (out_valid === 1'b1) && (out_ready === 1'b0);
      prev_y      = y;
      prev_zero   = zero;
      prev_parity = parity;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [W-1:0] da, input logic [W-1:0] db,
                       input logic [2:0] dop, input logic ordy);
    @(negedge clk);
    in_valid  = v;
    a         = da;
    b         = db;
    op        = dop;
    out_ready = ordy;
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_drain(input int max_cycles);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      drive(1'b0, '0, '0, 3'd0, 1'b1);
      n++;
    end
    drive(1'b0, '0, '0, 3'd0, 1'b1);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || y !== '0 || zero !== 1'b0 || parity !== 1'b0 || txn_cnt !== '0) begin
      tests_failed++;
      $display("FAIL reset_state: got v=%b y=%h z=%b p=%b cnt=%h expected all 0",
               out_valid, y, zero, parity, txn_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_single();
    drive(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b010, 1'b1);
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_in_ready: got %b expected 1", in_ready);
    end
    drive(1'b0, '0, '0, 3'd0, 1'b1);
    #1;
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_early_valid: got %b expected 0", out_valid);
    end
    drive(1'b0, '0, '0, 3'd0, 1'b1);
    #1;
    tests_run++;
    if (out_valid !== 1'b1 || y !== 32'h0 || zero !== 1'b1 || parity !== 1'b0 || txn_cnt !== 16'd1) begin
      tests_failed++;
      $display("FAIL single_result: got v=%b y=%h z=%b p=%b cnt=%0d expected v=1 y=0 z=1 p=0 cnt=1",
               out_valid, y, zero, parity, txn_cnt);
    end
    drive(1'b0, '0, '0, 3'd0, 1'b1);
    #1;
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_one_cycle: got out_valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] tbl [8];
    int k = 0;
    tbl = '{32'h0000_0000, 32'h03AF_5554, 32'h03AF_5554, 32'hFFFF_FFFF,
            32'hFC50_AAAB, 32'hFC50_AAAB, 32'h03AF_5554, 32'hFC50_AAAB};
    for (int i = 0; i < 12; i++) begin
      if (i < 8) drive(1'b1, 32'h03AF_5554, 32'h0, 3'(i), 1'b1);
      else       drive(1'b0, '0, '0, 3'd0, 1'b1);
      #1;
      if (out_valid === 1'b1 && k < 8) begin
        tests_run++;
        if (y !== tbl[k] || i != k + 2) begin
          tests_failed++;
          $display("FAIL b2b_result[%0d]: got y=%h at cycle %0d expected y=%h at cycle %0d",
                   k, y, i, tbl[k], k + 2);
        end
        k++;
      end
    end
    tests_run++;
    if (k != 8) begin
      tests_failed++;
      $display("FAIL b2b_count: got %0d results expected 8", k);
    end
  endtask

  task automatic test_backpressure();
    int acc = 0;
    int got = 0;
    logic [W-1:0] a1, b1;
    logic [2:0]   op1;
    logic [W-1:0] second;
    a1 = $urandom; b1 = $urandom; op1 = 3'($urandom_range(0, 7));
    second = ref_op(a1, b1, op1);
    for (int i = 0; i < 5; i++) begin
      if (i == 0)      drive(1'b1, 32'hC15D_F831, 32'hFE7B_F557, 3'b010, 1'b0);
      else if (i == 1) drive(1'b1, a1, b1, op1, 1'b0);
      else             drive(1'b1, $urandom, $urandom, 3'($urandom_range(0, 7)), 1'b0);
      #1;
      if (in_ready === 1'b1) acc++;
      if (i >= 2) begin
        tests_run++;
        if (out_valid !== 1'b1 || y !== 32'h3F26_0D66) begin
          tests_failed++;
          $display("FAIL bp_hold[%0d]: got v=%b y=%h expected v=1 y=3f260d66", i, out_valid, y);
        end
      end
    end
    tests_run++;
    if (acc != 2 || in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_accepts: got %0d accepts in_ready=%b expected 2 accepts in_ready=0",
               acc, in_ready);
    end
    for (int j = 0; j < 6; j++) begin
      drive(1'b0, '0, '0, 3'd0, 1'b1);
      #1;
      if (out_valid === 1'b1) begin
        tests_run++;
        if ((got == 0 && y !== 32'h3F26_0D66) || (got == 1 && y !== second) || got > 1) begin
          tests_failed++;
          $display("FAIL bp_release[%0d]: got y=%h expected %h", got, y,
                   (got == 0) ? 32'h3F26_0D66 : second);
        end
        got++;
      end
    end
    tests_run++;
    if (got != 2) begin
      tests_failed++;
      $display("FAIL bp_release_count: got %0d expected 2", got);
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] ra, rb, e;
    logic [2:0]   rop;
    logic         seen = 1'b0;
    drive(1'b1, $urandom, $urandom, 3'($urandom_range(0, 7)), 1'b0);
    drive(1'b1, $urandom, $urandom, 3'($urandom_range(0, 7)), 1'b0);
    drive(1'b0, '0, '0, 3'd0, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || y !== '0 || txn_cnt !== '0 || zero !== 1'b0 || parity !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_state: got v=%b y=%h cnt=%h z=%b p=%b expected all 0",
               out_valid, y, txn_cnt, zero, parity);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ra = $urandom; rb = $urandom; rop = 3'($urandom_range(0, 7));
    e  = ref_op(ra, rb, rop);
    drive(1'b1, ra, rb, rop, 1'b1);
    for (int i = 0; i < 6 && !seen; i++) begin
      drive(1'b0, '0, '0, 3'd0, 1'b1);
      #1;
      if (out_valid === 1'b1) begin
        seen = 1'b1;
        tests_run++;
        if (y !== e) begin
          tests_failed++;
          $display("FAIL midreset_first: got y=%h expected %h", y, e);
        end
      end
    end
    tests_run++;
    if (!seen) begin
      tests_failed++;
      $display("FAIL midreset_timeout: got no output expected y=%h", e);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 9) < 7, $urandom, $urandom, 3'($urandom_range(0, 7)),
            $urandom_range(0, 9) < 6);
    end
    wait_drain(20);
  endtask

  task automatic test_counter_wrap();
    int acc = 0;
    do_reset();
    for (int i = 0; i < 65536; i++) begin
      drive(1'b1, $urandom, $urandom, 3'($urandom_range(0, 7)), 1'b1);
      #1;
      if (in_ready === 1'b1) acc++;
    end
    wait_drain(10);
    #1;
    tests_run++;
    if (acc != 65536 || txn_cnt !== 16'h0000) begin
      tests_failed++;
      $display("FAIL cnt_wrap: got %0d accepts cnt=%h expected 65536 accepts cnt=0000", acc, txn_cnt);
    end
  endtask

`ifdef LU_POPCOUNT_EN
  task automatic test_popcount();
    drive(1'b1, 32'h771F_FE01, 32'h0, 3'b001, 1'b1);
    drive(1'b0, '0, '0, 3'd0, 1'b1);
    drive(1'b0, '0, '0, 3'd0, 1'b1);
    #1;
    tests_run++;
    if (out_valid !== 1'b1 || y !== 32'h771F_FE01 || popcnt !== PC_W'(19)) begin
      tests_failed++;
      $display("FAIL popcount: got v=%b y=%h pc=%0d expected v=1 y=771ffe01 pc=19",
               out_valid, y, popcnt);
    end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    op        = 3'd0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    wait_drain(10);
`ifdef LU_POPCOUNT_EN
    test_popcount();
    wait_drain(10);
`endif
    test_random();
    test_counter_wrap();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL final_queue: got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
